// File: rtl/dffre_bank_arbiter_pkg.sv
// Shared types, limits and helpers for the dffre bank write arbiter.
package dffre_arb_pkg;

    localparam int N_REQ_MIN   = 2;
    localparam int N_REQ_MAX   = 8;
    localparam int N_CELLS_MIN = 2;
    localparam int N_CELLS_MAX = 16;
    localparam int CELL_IDX_W  = $clog2(N_CELLS_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    // Cell index to one-hot enable, sized for the largest legal bank.
    function automatic logic [N_CELLS_MAX-1:0] onehot_dec(input logic [CELL_IDX_W-1:0] idx);
        logic [N_CELLS_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dffre_bank_arbiter_if.sv
// Requester/bank-side bus of the dffre bank arbiter.
// master = requester logic, slave = arbiter.
interface dffre_bank_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int N_CELLS = 8
);
    localparam int AW = $clog2(N_CELLS);

    logic                   i_Enable;
    logic [N_REQ-1:0]       i_Req;
    logic [N_REQ*AW-1:0]    i_Addr;
    logic [N_REQ-1:0]       i_D;
    logic [N_REQ-1:0]       o_Gnt;
    logic [N_CELLS-1:0]     o_CellEn;
    logic                   o_CellD;
    logic                   o_Busy;

    modport master (
        output i_Enable, i_Req, i_Addr, i_D,
        input  o_Gnt, o_CellEn, o_CellD, o_Busy
    );

    modport slave (
        input  i_Enable, i_Req, i_Addr, i_D,
        output o_Gnt, o_CellEn, o_CellD, o_Busy
    );

endinterface

// File: rtl/dffre_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the eligible vector so the
// search starts at i_ptr, take the lowest set bit, rotate the index back.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_win,
    output logic          o_valid
);

    logic [N-1:0]  rot;
    logic [PW:0]   idx;
    logic [PW-1:0] pos;
    logic [PW:0]   sum;

    // Rotate, priority-encode, rotate back.
    always_comb begin
        rot = '0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (PW+1)'(i) + {1'b0, i_ptr};
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            rot[i] = i_elig[idx[PW-1:0]];
        end

        pos = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) begin
                pos = PW'(i - 1);
            end
        end

        sum = {1'b0, pos} + {1'b0, i_ptr};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        o_win   = sum[PW-1:0];
        o_valid = |i_elig;
    end

endmodule

// File: rtl/dffre_bank_arbiter.sv
// Round-robin write arbiter in front of a bank of enable-gated reset flops.
// Grants at most one requester per cycle and drives a one-hot cell enable
// plus the shared data bit for that cell; all bank-facing outputs are flops.
module dffre_bank_arbiter
    import dffre_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_CELLS = 8
) (
    input  logic                 clk,
    input  logic                 i_Reset,
    dffre_bank_arbiter_if.slave  bus
);

    localparam int AW = $clog2(N_CELLS);
    localparam int PW = $clog2(N_REQ);

    arb_state_t         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_CELLS-1:0] cell_en_q, cell_en_d;
    logic               cell_d_q, cell_d_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic [N_REQ-1:0]   elig;
    logic [PW-1:0]      win;
    logic               win_valid;
    logic [AW-1:0]      win_addr;
    logic               win_d;

    // A requester whose grant is currently showing sits out one cycle.
    always_comb begin
        elig = bus.i_Req & ~((state_q == WRITE) ? gnt_q : '0);
    end

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_elig  (elig),
        .i_ptr   (ptr_q),
        .o_win   (win),
        .o_valid (win_valid)
    );

    // Select the winner's address and data slice.
    always_comb begin
        win_addr = '0;
        win_d    = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win == PW'(k)) begin
                win_addr = bus.i_Addr[k*AW +: AW];
                win_d    = bus.i_D[k];
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d   = IDLE;
        gnt_d     = '0;
        cell_en_d = '0;
        cell_d_d  = cell_d_q;
        ptr_d     = ptr_q;
        if (bus.i_Enable && win_valid) begin
            state_d    = WRITE;
            gnt_d[win] = 1'b1;
            cell_en_d  = N_CELLS'(onehot_dec(CELL_IDX_W'(win_addr)));
            cell_d_d   = win_d;
            ptr_d      = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // State, pointer and output registers; reset clears the bank enables at once.
    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cell_en_q <= '0;
            cell_d_q  <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cell_en_q <= cell_en_d;
            cell_d_q  <= cell_d_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.o_Gnt    = gnt_q;
    assign bus.o_CellEn = cell_en_q;
    assign bus.o_CellD  = cell_d_q;
    assign bus.o_Busy   = |elig;

endmodule

// File: tb/tb_dffre_bank_arbiter.sv
// Scoreboard bench for dffre_bank_arbiter with a behavioural flop bank.
module tb_dffre_bank_arbiter;

    localparam int NR = 4;
    localparam int NC = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic i_Reset;
    always #5 clk = ~clk;

    dffre_bank_arbiter_if #(.N_REQ(NR), .N_CELLS(NC)) bus();

    dffre_bank_arbiter #(.N_REQ(NR), .N_CELLS(NC)) dut (
        .clk     (clk),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    // Behavioural bank of dffre cells fed by the arbiter outputs.
    logic          bank_rst;
    logic [NC-1:0] bank_q;
    always @(posedge clk) begin
        if (bank_rst) bank_q <= '0;
        else          bank_q <= (bank_q & ~bus.o_CellEn) | (bus.o_CellD ? bus.o_CellEn : '0);
    end

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [NC-1:0] cen;
        logic          cd;
        logic          busy;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;

    logic [NR-1:0] m_gnt;
    logic [NC-1:0] m_cen;
    logic          m_cd;
    int            m_ptr;
    logic [NC-1:0] exp_bank;
    logic          busy_seen;

    task automatic model_clear();
        m_gnt = '0; m_cen = '0; m_cd = 1'b0; m_ptr = 0;
        sb.delete();
    endtask

    task automatic set_slot(input int k, input int a, input logic d);
        logic [1:0] kk;
        kk = 2'(k);
        bus.i_Addr[kk*AW +: AW] = 3'(a);
        bus.i_D[kk] = d;
    endtask

    // Predict the next registered outputs, push them, advance one clock.
    task automatic tick();
        exp_t          x;
        logic [NR-1:0] el;
        logic [1:0]    k, w;
        logic          hit;
        #1;
        busy_seen = bus.o_Busy;
        el  = bus.i_Req & ~m_gnt;
        hit = 1'b0;
        w   = '0;
        for (int i = 0; i < NR; i++) begin
            k = 2'((m_ptr + i) % NR);
            if (!hit && el[k]) begin hit = 1'b1; w = k; end
        end
        exp_bank = (exp_bank & ~m_cen) | (m_cd ? m_cen : '0);
        if (bus.i_Enable && hit) begin
            m_gnt = NR'(1) << w;
            m_cen = NC'(1) << bus.i_Addr[w*AW +: AW];
            m_cd  = bus.i_D[w];
            m_ptr = (int'(w) + 1) % NR;
        end else begin
            m_gnt = '0;
            m_cen = '0;
        end
        x.gnt = m_gnt; x.cen = m_cen; x.cd = m_cd; x.busy = |el;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #1;
        i_Reset = 1'b1;
        @(posedge clk);
        #1;
        i_Reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bus.i_Enable = 1'b1; bus.i_Req = '0; bus.i_Addr = '0; bus.i_D = '0;
        bank_rst = 1'b1; i_Reset = 1'b1;
        model_clear();
        exp_bank = '0;
        repeat (2) @(posedge clk);
        #1;
        bank_rst = 1'b0; i_Reset = 1'b0;
        checks++;
        if ({bus.o_Gnt, bus.o_CellEn, bus.o_CellD} !== '0) begin
            errors++; $display("FAIL reset_outputs got %b req 0", {bus.o_Gnt, bus.o_CellEn, bus.o_CellD});
        end
        for (int n = 0; n < 10; n++) begin
            tick(); e = sb.pop_front();
            checks++;
            if ({bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen} !== {e.gnt, e.cen, e.cd, e.busy} ||
                {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen} !== '0) begin
                errors++; $display("FAIL idle_cycle %0d got %b req %b", n,
                    {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen}, {e.gnt, e.cen, e.cd, e.busy});
            end
        end
    endtask

    task automatic test_single();
        set_slot(0, 5, 1'b1);
        bus.i_Req = 4'b0001;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0001 || bus.o_CellEn !== 8'h20 || bus.o_CellD !== 1'b1 ||
            {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen} !== {e.gnt, e.cen, e.cd, e.busy}) begin
            errors++; $display("FAIL single_grant got %b req %b",
                {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen}, {e.gnt, e.cen, e.cd, e.busy});
        end
        bus.i_Req = '0;
        tick(); e = sb.pop_front();
        checks++;
        if (bank_q[5] !== 1'b1 || bank_q !== exp_bank || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL single_cell got bank %b gnt %b req bank %b gnt %b", bank_q, bus.o_Gnt, exp_bank, e.gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] ord [5];
        logic [NR-1:0] prev;
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        set_slot(0, 0, 1'b1); set_slot(1, 1, 1'b0); set_slot(2, 2, 1'b1); set_slot(3, 4, 1'b0);
        bus.i_Req = 4'b1111;
        prev = '0;
        for (int n = 0; n < 5; n++) begin
            tick(); e = sb.pop_front();
            checks++;
            if (bus.o_Gnt !== ord[n] || {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen} !== {e.gnt, e.cen, e.cd, e.busy}) begin
                errors++; $display("FAIL rr_order %0d got %b req %b (gnt %b)", n,
                    {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen}, {e.gnt, e.cen, e.cd, e.busy}, ord[n]);
            end
            checks++;
            if ((bus.o_Gnt & prev) !== '0) begin
                errors++; $display("FAIL rr_repeat %0d got %b after %b req no overlap", n, bus.o_Gnt, prev);
            end
            prev = bus.o_Gnt;
        end
        bus.i_Req = '0;
        repeat (2) begin
            tick(); e = sb.pop_front();
        end
        checks++;
        if (bank_q !== exp_bank || bank_q[4:0] !== 5'b00101 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL rr_bank got %b req %b", bank_q, exp_bank);
        end
    endtask

    task automatic test_same_cell();
        apply_reset();
        set_slot(1, 3, 1'b0); set_slot(2, 3, 1'b1);
        bus.i_Req = 4'b0110;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0010 || bus.o_CellEn !== 8'h08 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL same_cell_first got %b req 0010", bus.o_Gnt);
        end
        bus.i_Req = 4'b0100;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0100 || bus.o_CellEn !== 8'h08 || bus.o_CellD !== 1'b1 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL same_cell_second got %b req 0100", bus.o_Gnt);
        end
        bus.i_Req = '0;
        repeat (2) begin
            tick(); e = sb.pop_front();
        end
        checks++;
        if (bank_q[3] !== 1'b1 || bank_q !== exp_bank) begin
            errors++; $display("FAIL same_cell_last_wins got %b req %b", bank_q, exp_bank);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        set_slot(1, 6, 1'b1); set_slot(2, 7, 1'b0);
        bus.i_Enable = 1'b0;
        bus.i_Req = 4'b0110;
        for (int n = 0; n < 5; n++) begin
            tick(); e = sb.pop_front();
            checks++;
            if (bus.o_Gnt !== '0 || bus.o_CellEn !== '0 || busy_seen !== 1'b1 ||
                {bus.o_Gnt, busy_seen} !== {e.gnt, e.busy}) begin
                errors++; $display("FAIL stall %0d got gnt %b busy %b req gnt 0000 busy 1", n, bus.o_Gnt, busy_seen);
            end
        end
        bus.i_Enable = 1'b1;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0010 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL reenable_first got %b req 0010", bus.o_Gnt);
        end
        bus.i_Req = 4'b0100;
        bus.i_Enable = 1'b0;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== '0 || bus.o_CellEn !== '0 || busy_seen !== 1'b1 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL enable_fall got gnt %b busy %b req gnt 0000 busy 1", bus.o_Gnt, busy_seen);
        end
        bus.i_Enable = 1'b1;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0100 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL enable_resume got %b req 0100", bus.o_Gnt);
        end
        bus.i_Req = '0;
        tick(); e = sb.pop_front();
    endtask

    task automatic test_reset_mid_write();
        set_slot(2, 7, 1'b1);
        bus.i_Req = 4'b0100;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0100 || bus.o_CellEn !== 8'h80 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL midreset_setup got %b/%h req 0100/80", bus.o_Gnt, bus.o_CellEn);
        end
        #1;
        i_Reset = 1'b1;
        #1;
        checks++;
        if (bus.o_CellEn !== '0 || bus.o_Gnt !== '0) begin
            errors++; $display("FAIL midreset_async got cen %h gnt %b req 00/0000", bus.o_CellEn, bus.o_Gnt);
        end
        model_clear();
        bus.i_Req = '0;
        @(posedge clk);
        #1;
        i_Reset = 1'b0;
        checks++;
        if (bank_q[7] !== 1'b0 || bank_q !== exp_bank) begin
            errors++; $display("FAIL midreset_bank got %b req %b", bank_q, exp_bank);
        end
        set_slot(0, 0, 1'b0); set_slot(3, 1, 1'b0);
        bus.i_Req = 4'b1001;
        tick(); e = sb.pop_front();
        checks++;
        if (bus.o_Gnt !== 4'b0001 || bus.o_Gnt !== e.gnt) begin
            errors++; $display("FAIL midreset_ptr got %b req 0001", bus.o_Gnt);
        end
        bus.i_Req = 4'b1000;
        tick(); e = sb.pop_front();
        bus.i_Req = '0;
        tick(); e = sb.pop_front();
    endtask

    task automatic test_random();
        logic [1:0] kk;
        int         bad;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < NR; k++) begin
                kk = 2'(k);
                if (!bus.i_Req[kk]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.i_Req[kk] = 1'b1;
                        set_slot(k, int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)));
                    end
                end else if (m_gnt[kk]) begin
                    if ($urandom_range(0, 1) == 0) bus.i_Req[kk] = 1'b0;
                    else set_slot(k, int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)));
                end
            end
            bus.i_Enable = ($urandom_range(0, 9) != 0);
            tick(); e = sb.pop_front();
            checks++;
            if ({bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen} !== {e.gnt, e.cen, e.cd, e.busy}) begin
                errors++;
                if (bad < 10) $display("FAIL random_out %0d got %b req %b", n,
                    {bus.o_Gnt, bus.o_CellEn, bus.o_CellD, busy_seen}, {e.gnt, e.cen, e.cd, e.busy});
                bad++;
            end
            checks++;
            if (bank_q !== exp_bank) begin
                errors++;
                if (bad < 10) $display("FAIL random_bank %0d got %b req %b", n, bank_q, exp_bank);
                bad++;
            end
        end
        bus.i_Req = '0;
        bus.i_Enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_cell();
        test_enable();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/dffre_bank_arbiter.md
# dffre_bank_arbiter

Round-robin write arbiter that shares a bank of `N_CELLS` enable-gated reset flops (dffre_inst cells) between `N_REQ` requesters. Each cycle at most one requester is granted. The arbiter then drives a one-hot cell enable and the write data for that cell, so exactly one dffre cell captures per write. It sits between requester logic and the flop bank, and owns every `i_Enable`/`i_D` pin of the bank.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8)
- `N_CELLS`, 8: number of dffre cells in the bank (power of two, 2..16)
- `AW`, `$clog2(N_CELLS)`: cell address width (derived; not overridden)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge
- `i_Reset`  in  1  asynchronous active-high reset
- `i_Enable`  in  1  global run; 0 = stall arbitration, hold pending requests
- `i_Req`  in  `N_REQ`  per-requester write request (level)
- `i_Addr`  in  `N_REQ*AW`  target cell index, packed; slice k belongs to requester k
- `i_D`  in  `N_REQ`  write data bit per requester
- `o_Gnt`  out  `N_REQ`  one-cycle grant pulse, one-hot or zero
- `o_CellEn`  out  `N_CELLS`  one-hot enable to the bank's `i_Enable` pins
- `o_CellD`  out  1  shared data to the bank's `i_D` pins
- `o_Busy`  out  1  high while any unmasked request is pending

## Operation
- States: `IDLE` (no grant in flight) and `WRITE` (`o_Gnt`/`o_CellEn` asserted this cycle).
- Eligible set = `i_Req & ~o_Gnt`. A requester whose grant is showing this cycle is masked, so each requester gets at most one grant every 2 cycles.
- When `i_Enable`=1 and the eligible set is non-empty:
  - the round-robin picker selects winner w, starting the search at `ptr`;
  - at the next edge: `o_Gnt`=onehot(w), `o_CellEn`=onehot(`i_Addr[w]`), `o_CellD`=`i_D[w]`, `ptr`=(w+1) mod `N_REQ`, state=`WRITE`.
- When `i_Enable`=0 or the eligible set is empty: the next edge clears `o_Gnt`/`o_CellEn`, holds `o_CellD` and `ptr`, and moves state to `IDLE`.
- Back-to-back grants to different requesters are allowed (`WRITE`→`WRITE`).
- Requester contract:
  - hold `i_Req`, `i_Addr`, `i_D` stable until `o_Gnt[k]` is seen;
  - deassert `i_Req` in the cycle `o_Gnt[k]`=1, or keep it asserted to request another write.
- Two requesters targeting the same cell: both are served in pointer order; the last write wins.
- `o_Busy` = |(eligible set), combinational.

## Timing
- Request sampled at edge t → `o_Gnt`/`o_CellEn`/`o_CellD` valid after edge t → bank cell captures at edge t+1. Request-to-cell-update latency is 2 edges.
- All outputs except `o_Busy` are registered.
- Reset values: `o_Gnt`=0, `o_CellEn`=0, `o_CellD`=0, `ptr`=0, state=`IDLE`. `o_Busy` follows its inputs.
- `i_Reset` mid-`WRITE`: outputs clear immediately (asynchronously), so the bank sees `i_Enable`=0. The in-flight write is dropped, and its requester must re-request.
- `i_Enable` falling while in `WRITE`: the current pulse completes; no new grant is issued.
- Pointer wrap: winner `N_REQ`-1 → `ptr`=0.

## Structure
- Package `dffre_arb_pkg`:
  - `arb_state_t` enum {`IDLE`, `WRITE`};
  - function `onehot_dec` (index → one-hot);
  - localparam limits for `N_REQ`/`N_CELLS`.
- Sub-module `rr_pick`:
  - purely combinational rotate-priority-rotate picker;
  - inputs: eligible vector, `ptr`;
  - outputs: winner index, valid.
- Top holds the state register, pointer, and output registers.

## Test plan
- Reset, then `i_Req`=0 for 10 cycles → all outputs 0, `o_Busy`=0.
- `i_Req`=4'b0001, `i_Addr[0]`=5, `i_D[0]`=1 → `o_Gnt`=0001 and `o_CellEn`=8'h20, `o_CellD`=1 one cycle later; golden dffre cell 5 shows `o_Q`=1 after the next edge.
- `i_Req`=4'b1111 held, distinct addresses → grant order 0,1,2,3,0 on consecutive cycles; no requester granted in 2 consecutive cycles.
- Requesters 1 and 2 target cell 3 with D=0 and D=1, `ptr`=0 → grant 1 then 2; cell 3 ends at 1.
- `i_Enable`=0 with `i_Req`=4'b0110 for 5 cycles → no grants, `o_Busy`=1. Re-enable → grant 0010 first.
- Assert `i_Reset` during a `WRITE` cycle → `o_CellEn` clears that cycle, no cell changes value, `ptr`=0 after release. Also run 1000 random req/addr/D cycles against a behavioural bank model: zero mismatches.
